// File: rtl/risc_ctrl_pkg.sv
// Shared encodings for the RISC multi-cycle sequencer: states, opcodes,
// ALU function codes and the decoded opcode class record.
package risc_ctrl_pkg;

   localparam int unsigned OPW  = 4;
   localparam int unsigned STW  = 3;
   localparam int unsigned ALUW = 3;

   typedef enum logic [STW-1:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_DECODE = 3'd2,
      ST_EXEC   = 3'd3,
      ST_MEM    = 3'd4,
      ST_WB     = 3'd5,
      ST_HALT   = 3'd6,
      ST_BAD    = 3'd7
   } state_e;

   localparam logic [OPW-1:0] OP_NOP = 4'b0000;
   localparam logic [OPW-1:0] OP_ADD = 4'b0001;
   localparam logic [OPW-1:0] OP_SUB = 4'b0010;
   localparam logic [OPW-1:0] OP_AND = 4'b0011;
   localparam logic [OPW-1:0] OP_OR  = 4'b0100;
   localparam logic [OPW-1:0] OP_LD  = 4'b0101;
   localparam logic [OPW-1:0] OP_ST  = 4'b0110;
   localparam logic [OPW-1:0] OP_BEQ = 4'b0111;
   localparam logic [OPW-1:0] OP_JMP = 4'b1000;
   localparam logic [OPW-1:0] OP_HLT = 4'b1111;

   localparam logic [ALUW-1:0] ALU_NONE = 3'b000;
   localparam logic [ALUW-1:0] ALU_ADD  = 3'b001;
   localparam logic [ALUW-1:0] ALU_SUB  = 3'b010;
   localparam logic [ALUW-1:0] ALU_AND  = 3'b011;
   localparam logic [ALUW-1:0] ALU_OR   = 3'b100;

   typedef struct packed {
      logic is_rtype;
      logic is_ld;
      logic is_st;
      logic is_beq;
      logic is_jmp;
      logic is_hlt;
      logic is_illegal;
   } op_class_t;

endpackage

// File: rtl/risc_cycle_sequencer_if.sv
// Control bundle between the sequencer (master) and the datapath/IR side (slave).
interface risc_cycle_sequencer_if;
   import risc_ctrl_pkg::*;

   logic            RUN;
   logic [OPW-1:0]  OPCODE;
   logic            MEM_ACK;
   logic            ZERO;

   logic            PC_LD;
   logic            PC_INC;
   logic            IR_LD;
   logic            A_LD;
   logic            B_LD;
   logic            MDR_LD;
   logic            RF_WE;
   logic [ALUW-1:0] ALU_OP;
   logic            MEM_REQ;
   logic            MEM_WE;
   logic            MAR_SEL;
   logic            WB_SEL;
   logic            HALTED;
   logic            ILLEGAL;
   logic [STW-1:0]  STATE;

   modport master (
      input  RUN, OPCODE, MEM_ACK, ZERO,
      output PC_LD, PC_INC, IR_LD, A_LD, B_LD, MDR_LD, RF_WE, ALU_OP,
             MEM_REQ, MEM_WE, MAR_SEL, WB_SEL, HALTED, ILLEGAL, STATE
   );

   modport slave (
      output RUN, OPCODE, MEM_ACK, ZERO,
      input  PC_LD, PC_INC, IR_LD, A_LD, B_LD, MDR_LD, RF_WE, ALU_OP,
             MEM_REQ, MEM_WE, MAR_SEL, WB_SEL, HALTED, ILLEGAL, STATE
   );

endinterface

// File: rtl/risc_op_decode.sv
// Combinational opcode classifier; NOP yields no flags, undefined codes flag is_illegal.
module risc_op_decode
   import risc_ctrl_pkg::*;
(
   input  logic [OPW-1:0] op,
   output op_class_t      cls
);

   always_comb begin
      cls = '0;
      case (op)
         OP_ADD, OP_SUB, OP_AND, OP_OR: cls.is_rtype = 1'b1;
         OP_LD:   cls.is_ld      = 1'b1;
         OP_ST:   cls.is_st      = 1'b1;
         OP_BEQ:  cls.is_beq     = 1'b1;
         OP_JMP:  cls.is_jmp     = 1'b1;
         OP_HLT:  cls.is_hlt     = 1'b1;
         OP_NOP:  cls            = '0;
         default: cls.is_illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/risc_cycle_sequencer.sv
// Multi-cycle fetch/decode/exec/mem/wb sequencer driving the datapath load strobes.
// State and opcode latch update on the falling edge of CLK.
module risc_cycle_sequencer
   import risc_ctrl_pkg::*;
(
   input logic                   CLK,
   input logic                   R_,
   risc_cycle_sequencer_if.master bus
);

   state_e          state_q, state_d;
   logic [OPW-1:0]  op_q;
   logic [OPW-1:0]  dec_op;
   op_class_t       cls;

   logic            pc_ld, pc_inc, ir_ld, a_ld, b_ld, mdr_ld, rf_we;
   logic [ALUW-1:0] alu_op;
   logic            mem_req, mem_we, mar_sel, wb_sel, halted, illegal;
   logic            boundary_fetch;

   // In DECODE the IR field is classified directly; afterwards the latched copy is used
   assign dec_op = (state_q == ST_DECODE) ? bus.OPCODE : op_q;

   risc_op_decode u_decode (
      .op  (dec_op),
      .cls (cls)
   );

   always_ff @(negedge CLK) begin
      if (!R_) begin
         state_q <= ST_IDLE;
         op_q    <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == ST_DECODE) op_q <= bus.OPCODE;
      end
   end

   assign boundary_fetch = bus.RUN;

   always_comb begin
      state_d = state_q;
      pc_ld   = 1'b0;
      pc_inc  = 1'b0;
      ir_ld   = 1'b0;
      a_ld    = 1'b0;
      b_ld    = 1'b0;
      mdr_ld  = 1'b0;
      rf_we   = 1'b0;
      alu_op  = ALU_NONE;
      mem_req = 1'b0;
      mem_we  = 1'b0;
      mar_sel = 1'b0;
      wb_sel  = 1'b0;
      halted  = 1'b0;
      illegal = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (bus.RUN) state_d = ST_FETCH;
         end
         ST_FETCH: begin
            mem_req = 1'b1;
            if (bus.MEM_ACK) begin
               ir_ld   = 1'b1;
               pc_inc  = 1'b1;
               state_d = ST_DECODE;
            end
         end
         ST_DECODE: begin
            a_ld    = 1'b1;
            b_ld    = 1'b1;
            illegal = cls.is_illegal;
            if (cls.is_hlt)
               state_d = ST_HALT;
            else if (cls.is_rtype | cls.is_ld | cls.is_st | cls.is_beq | cls.is_jmp)
               state_d = ST_EXEC;
            else
               state_d = boundary_fetch ? ST_FETCH : ST_IDLE;
         end
         ST_EXEC: begin
            if (cls.is_rtype) begin
               alu_op  = op_q[ALUW-1:0];
               state_d = ST_WB;
            end else if (cls.is_ld | cls.is_st) begin
               alu_op  = ALU_ADD;
               state_d = ST_MEM;
            end else begin
               if (cls.is_beq) begin
                  alu_op = ALU_SUB;
                  pc_ld  = bus.ZERO;
               end else begin
                  pc_ld  = cls.is_jmp;
               end
               state_d = boundary_fetch ? ST_FETCH : ST_IDLE;
            end
         end
         ST_MEM: begin
            mem_req = 1'b1;
            mar_sel = 1'b1;
            mem_we  = cls.is_st;
            if (bus.MEM_ACK) begin
               if (cls.is_ld) begin
                  mdr_ld  = 1'b1;
                  state_d = ST_WB;
               end else begin
                  state_d = boundary_fetch ? ST_FETCH : ST_IDLE;
               end
            end
         end
         ST_WB: begin
            rf_we   = 1'b1;
            wb_sel  = cls.is_ld;
            alu_op  = cls.is_rtype ? op_q[ALUW-1:0] : ALU_ADD;
            state_d = boundary_fetch ? ST_FETCH : ST_IDLE;
         end
         ST_HALT: begin
            halted = 1'b1;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Same-cycle strobes must not fire for an instruction that reset is aborting
      if (!R_) begin
         pc_ld  = 1'b0;
         pc_inc = 1'b0;
         ir_ld  = 1'b0;
         mdr_ld = 1'b0;
      end
   end

   assign bus.PC_LD   = pc_ld;
   assign bus.PC_INC  = pc_inc;
   assign bus.IR_LD   = ir_ld;
   assign bus.A_LD    = a_ld;
   assign bus.B_LD    = b_ld;
   assign bus.MDR_LD  = mdr_ld;
   assign bus.RF_WE   = rf_we;
   assign bus.ALU_OP  = alu_op;
   assign bus.MEM_REQ = mem_req;
   assign bus.MEM_WE  = mem_we;
   assign bus.MAR_SEL = mar_sel;
   assign bus.WB_SEL  = wb_sel;
   assign bus.HALTED  = halted;
   assign bus.ILLEGAL = illegal;
   assign bus.STATE   = STW'(state_q);

endmodule

// File: tb/tb_risc_cycle_sequencer.sv
// Directed per-cycle vector bench for risc_cycle_sequencer; one record per CLK cycle
// holding inputs and the expected state/strobes seen before the next falling edge.
module tb_risc_cycle_sequencer;

   localparam logic [15:0] M_PCLD  = 16'h8000;
   localparam logic [15:0] M_PCINC = 16'h4000;
   localparam logic [15:0] M_IRLD  = 16'h2000;
   localparam logic [15:0] M_A     = 16'h1000;
   localparam logic [15:0] M_B     = 16'h0800;
   localparam logic [15:0] M_MDR   = 16'h0400;
   localparam logic [15:0] M_RFWE  = 16'h0200;
   localparam logic [15:0] M_MREQ  = 16'h0020;
   localparam logic [15:0] M_MWE   = 16'h0010;
   localparam logic [15:0] M_MAR   = 16'h0008;
   localparam logic [15:0] M_WBSEL = 16'h0004;
   localparam logic [15:0] M_HALT  = 16'h0002;
   localparam logic [15:0] M_ILL   = 16'h0001;
   localparam logic [15:0] M_FACK  = M_MREQ | M_IRLD | M_PCINC;
   localparam logic [15:0] M_AB    = M_A | M_B;

   typedef struct {
      string       nm;
      logic        rn;
      logic        run;
      logic [3:0]  op;
      logic        ack;
      logic        zero;
      logic [2:0]  st;
      logic [15:0] out;
   } vec_t;

   logic CLK = 1'b1;
   logic R_;
   int   n_vec = 0;
   int   n_err = 0;
   vec_t vecs[$];

   risc_cycle_sequencer_if bus();

   risc_cycle_sequencer dut (
      .CLK (CLK),
      .R_  (R_),
      .bus (bus)
   );

   always #5 CLK = ~CLK;

   function automatic logic [15:0] alu(input logic [2:0] a);
      return {7'b0, a, 6'b0};
   endfunction

   function automatic void add(input string nm, input logic rn, input logic run,
                               input logic [3:0] op, input logic ack, input logic zero,
                               input logic [2:0] st, input logic [15:0] out);
      vec_t v;
      v.nm = nm; v.rn = rn; v.run = run; v.op = op; v.ack = ack; v.zero = zero;
      v.st = st; v.out = out;
      vecs.push_back(v);
   endfunction

   function automatic logic [15:0] actual_out();
      return {bus.PC_LD, bus.PC_INC, bus.IR_LD, bus.A_LD, bus.B_LD, bus.MDR_LD,
              bus.RF_WE, bus.ALU_OP, bus.MEM_REQ, bus.MEM_WE, bus.MAR_SEL,
              bus.WB_SEL, bus.HALTED, bus.ILLEGAL};
   endfunction

   task automatic check(input string nm, input logic [2:0] st, input logic [15:0] out);
      logic [15:0] act;
      act = actual_out();
      n_vec++;
      if (bus.STATE !== st || act !== out) begin
         n_err++;
         $display("FAIL %s: got STATE=%0d strobes=%04h, expected STATE=%0d strobes=%04h",
                  nm, bus.STATE, act, st, out);
      end
   endtask

   task automatic drive(input logic rn, input logic run, input logic [3:0] op,
                        input logic ack, input logic zero);
      R_          = rn;
      bus.RUN     = run;
      bus.OPCODE  = op;
      bus.MEM_ACK = ack;
      bus.ZERO    = zero;
   endtask

   initial begin
      drive(1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
      repeat (2) @(negedge CLK);

      // reset and idle
      add("rst_hold",  0,0,4'h0,0,0, 0, '0);
      add("idle_ack",  1,0,4'h0,1,0, 0, '0);
      // ADD, zero-wait: 1,2,3,5 then back to FETCH
      add("add_idle",  1,1,4'h0,0,0, 0, '0);
      add("add_fetch", 1,1,4'h0,1,0, 1, M_FACK);
      add("add_dec",   1,1,4'h1,0,0, 2, M_AB);
      add("add_exec",  1,1,4'h1,1,1, 3, alu(3'b001));
      add("add_wb",    1,1,4'h1,0,0, 5, M_RFWE | alu(3'b001));
      // LD, two wait cycles in FETCH and in MEM; IR field changes after DECODE
      add("ld_f_w1",   1,1,4'h0,0,0, 1, M_MREQ);
      add("ld_f_w2",   1,1,4'h0,0,0, 1, M_MREQ);
      add("ld_f_ack",  1,1,4'h0,1,0, 1, M_FACK);
      add("ld_dec",    1,1,4'h5,0,0, 2, M_AB);
      add("ld_exec",   1,1,4'h0,0,0, 3, alu(3'b001));
      add("ld_m_w1",   1,1,4'h0,0,0, 4, M_MREQ | M_MAR);
      add("ld_m_w2",   1,1,4'h0,0,0, 4, M_MREQ | M_MAR);
      add("ld_m_ack",  1,1,4'h0,1,0, 4, M_MREQ | M_MAR | M_MDR);
      add("ld_wb",     1,1,4'h0,0,0, 5, M_RFWE | M_WBSEL | alu(3'b001));
      // ST
      add("st_fetch",  1,1,4'h0,1,0, 1, M_FACK);
      add("st_dec",    1,1,4'h6,0,0, 2, M_AB);
      add("st_exec",   1,1,4'h6,0,0, 3, alu(3'b001));
      add("st_mem",    1,1,4'h6,1,0, 4, M_MREQ | M_MWE | M_MAR);
      // BEQ taken, then not taken
      add("beq1_f",    1,1,4'h0,1,1, 1, M_FACK);
      add("beq1_dec",  1,1,4'h7,0,1, 2, M_AB);
      add("beq1_exec", 1,1,4'h7,0,1, 3, alu(3'b010) | M_PCLD);
      add("beq0_f",    1,1,4'h0,1,0, 1, M_FACK);
      add("beq0_dec",  1,1,4'h7,0,0, 2, M_AB);
      add("beq0_exec", 1,1,4'h7,0,0, 3, alu(3'b010));
      // JMP
      add("jmp_f",     1,1,4'h0,1,0, 1, M_FACK);
      add("jmp_dec",   1,1,4'h8,0,0, 2, M_AB);
      add("jmp_exec",  1,1,4'h8,0,0, 3, M_PCLD);
      // illegal 1010 behaves as NOP
      add("ill_f",     1,1,4'h0,1,0, 1, M_FACK);
      add("ill_dec",   1,1,4'hA,0,0, 2, M_AB | M_ILL);
      // NOP with RUN dropped at the boundary
      add("nop_f",     1,1,4'h0,1,0, 1, M_FACK);
      add("nop_dec",   1,0,4'h0,0,0, 2, M_AB);
      add("nop_idle",  1,0,4'h0,1,0, 0, '0);
      // RUN dropped mid-LD: instruction completes, then IDLE
      add("rd_idle",   1,1,4'h0,0,0, 0, '0);
      add("rd_f",      1,0,4'h0,1,0, 1, M_FACK);
      add("rd_dec",    1,0,4'h5,0,0, 2, M_AB);
      add("rd_exec",   1,0,4'h5,0,0, 3, alu(3'b001));
      add("rd_mem",    1,0,4'h5,1,0, 4, M_MREQ | M_MAR | M_MDR);
      add("rd_wb",     1,0,4'h5,0,0, 5, M_RFWE | M_WBSEL | alu(3'b001));
      add("rd_idle2",  1,0,4'h5,0,0, 0, '0);
      // reset during the MEM wait of an LD
      add("rm_idle",   1,1,4'h0,0,0, 0, '0);
      add("rm_f",      1,1,4'h0,1,0, 1, M_FACK);
      add("rm_dec",    1,1,4'h5,0,0, 2, M_AB);
      add("rm_exec",   1,1,4'h5,0,0, 3, alu(3'b001));
      add("rm_mwait",  1,1,4'h5,0,0, 4, M_MREQ | M_MAR);
      add("rm_rst",    0,1,4'h5,0,0, 4, M_MREQ | M_MAR);
      add("rm_after",  1,0,4'h5,1,0, 0, '0);
      add("rm_after2", 1,0,4'h5,0,0, 0, '0);
      // HLT entry
      add("h_idle",    1,1,4'h0,0,0, 0, '0);
      add("h_f",       1,1,4'h0,1,0, 1, M_FACK);
      add("h_dec",     1,1,4'hF,0,0, 2, M_AB);

      foreach (vecs[i]) begin
         @(posedge CLK);
         drive(vecs[i].rn, vecs[i].run, vecs[i].op, vecs[i].ack, vecs[i].zero);
         #1;
         check(vecs[i].nm, vecs[i].st, vecs[i].out);
      end

      // HALT holds for 20 cycles whatever RUN/MEM_ACK/ZERO do
      for (int c = 0; c < 20; c++) begin
         @(posedge CLK);
         drive(1'b1, 1'(($urandom_range(0, 1))), 4'($urandom_range(0, 15)),
               1'(($urandom_range(0, 1))), 1'(($urandom_range(0, 1))));
         #1;
         check($sformatf("halt_hold%0d", c), 3'd6, M_HALT);
      end

      // only reset leaves HALT
      @(posedge CLK);
      drive(1'b0, 1'b1, 4'h0, 1'b1, 1'b0);
      #1;
      check("halt_rst", 3'd6, M_HALT);
      @(posedge CLK);
      drive(1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
      #1;
      check("halt_exit", 3'd0, '0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
